// File: rtl/dff_delay_line_if.sv
// Data/control bundle for dff_delay_line. The occ count is present only
// when DFF_DELAY_LINE_OCC_EN is defined.
interface dff_delay_line_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
`ifdef DFF_DELAY_LINE_OCC_EN
  logic [OCC_W-1:0] occ;
`endif

  // The master drives samples in and observes the far end of the line.
  modport master (
    output en, clr, d, d_valid,
`ifdef DFF_DELAY_LINE_OCC_EN
    input  occ,
`endif
    input  q, q_valid
  );

  modport slave (
    input  en, clr, d, d_valid,
`ifdef DFF_DELAY_LINE_OCC_EN
    output occ,
`endif
    output q, q_valid
  );

endinterface

// File: rtl/dff_delay_line.sv
// DEPTH-stage register delay line with per-stage valid flags, enable and
// synchronous flush. Define DFF_DELAY_LINE_OCC_EN to add the occupancy count.
module dff_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dff_delay_line_if.slave         bus
);

  // Elaboration-time guards on the legal parameter ranges and on the
  // interface instance being sized the same as this block.
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("dff_delay_line: WIDTH %0d outside 1..64", WIDTH);
  end
  if (DEPTH < 1 || DEPTH > 32) begin : g_bad_depth
    $error("dff_delay_line: DEPTH %0d outside 1..32", DEPTH);
  end
  if ($bits(bus.d) != WIDTH) begin : g_bad_bus
    $error("dff_delay_line: interface WIDTH does not match block WIDTH");
  end

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic             valid_q [DEPTH];

  // NOTE: every stage, not just the output one, is reset so that an
  // asynchronous reset discards all in-flight samples rather than letting
  // stale data walk out after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else if (bus.clr) begin
      // Flush wins over enable, so a coincident input sample is dropped.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
    end else if (bus.en) begin
      // NOTE: non-blocking assignments make every stage read its
      // neighbour's pre-edge value, so the loop order does not matter.
      data_q[0]  <= bus.d;
      valid_q[0] <= bus.d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Outputs come straight from the last stage: no path from d, en or clr.
  assign bus.q       = data_q[DEPTH-1];
  assign bus.q_valid = valid_q[DEPTH-1];

`ifdef DFF_DELAY_LINE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_next;

  // One sample enters and the last-stage sample leaves on each enabled
  // edge, which keeps the count equal to the number of set valid flags.
  always_comb begin
    occ_next = occ_q + OCC_W'(bus.d_valid) - OCC_W'(valid_q[DEPTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (bus.clr) begin
      occ_q <= '0;
    end else if (bus.en) begin
      occ_q <= occ_next;
    end
  end

  assign bus.occ = occ_q;
`endif

endmodule

// File: tb/tb_dff_delay_line.sv
// Directed bench for dff_delay_line (WIDTH=8, DEPTH=4, plus a DEPTH=1 copy);
// occupancy checks are compiled in with DFF_DELAY_LINE_OCC_EN.
module tb_dff_delay_line;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  dff_delay_line_if #(.WIDTH(8), .DEPTH(4)) bus  ();
  dff_delay_line_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

  dff_delay_line #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  dff_delay_line #(.WIDTH(8), .DEPTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs to the DEPTH=4 line, take one edge, sample 1 ns later.
  task automatic step(input logic en, input logic clr, input logic [7:0] d, input logic dv);
    bus.en      = en;
    bus.clr     = clr;
    bus.d       = d;
    bus.d_valid = dv;
    @(posedge clk);
    #1;
  endtask

`ifdef DFF_DELAY_LINE_OCC_EN
  int occ_peak;
`endif

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.clr      = 1'b0;
    bus.d        = 8'h00;
    bus.d_valid  = 1'b0;
    bus1.en      = 1'b0;
    bus1.clr     = 1'b0;
    bus1.d       = 8'h00;
    bus1.d_valid = 1'b0;

    // Reset state
    #1;
    check("rst_q", bus.q, 0);
    check("rst_q_valid", bus.q_valid, 0);
    check("rst_q1", bus1.q, 0);
`ifdef DFF_DELAY_LINE_OCC_EN
    check("rst_occ", bus.occ, 0);
`endif
    #6 rst_n = 1'b1;

    // Latency: 0x11 reaches q after the 4th enabled edge
    step(1, 0, 8'h11, 1);
    check("lat_e1_q_valid", bus.q_valid, 0);
    step(1, 0, 8'h22, 1);
    step(1, 0, 8'h33, 1);
    check("lat_e3_q_valid", bus.q_valid, 0);
    step(1, 0, 8'h44, 1);
    check("lat_e4_q", bus.q, 8'h11);
    check("lat_e4_q_valid", bus.q_valid, 1);
    step(1, 0, 8'h55, 1);
    check("lat_e5_q", bus.q, 8'h22);
`ifdef DFF_DELAY_LINE_OCC_EN
    check("lat_e5_occ", bus.occ, 4);
`endif

    // Flush with en low
    step(0, 1, 8'h00, 0);
    check("clr_en0_q", bus.q, 0);
    check("clr_en0_q_valid", bus.q_valid, 0);

    // Stall: fill with A1..A4, then hold for 3 edges with d=FF
    step(1, 0, 8'hA1, 1);
    step(1, 0, 8'hA2, 1);
    step(1, 0, 8'hA3, 1);
    step(1, 0, 8'hA4, 1);
    check("stall_fill_q", bus.q, 8'hA1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'hFF, 1);
      check("stall_hold_q", bus.q, 8'hA1);
      check("stall_hold_q_valid", bus.q_valid, 1);
`ifdef DFF_DELAY_LINE_OCC_EN
      check("stall_hold_occ", bus.occ, 4);
`endif
    end
    step(1, 0, 8'hA5, 1);
    check("stall_resume_q", bus.q, 8'hA2);

    // Flush: full line, clr with en and d=77 -> empty, 77 never appears
    step(1, 1, 8'h77, 1);
    check("flush_q", bus.q, 0);
    check("flush_q_valid", bus.q_valid, 0);
`ifdef DFF_DELAY_LINE_OCC_EN
    check("flush_occ", bus.occ, 0);
`endif
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'h00, 0);
      check("flush_drain_q", bus.q, 0);
      check("flush_drain_q_valid", bus.q_valid, 0);
    end

    // Bubbles: valid pattern 1,0,1,0; invalid data still shifts
`ifdef DFF_DELAY_LINE_OCC_EN
    occ_peak = 0;
`endif
    step(1, 0, 8'h01, 1);
    step(1, 0, 8'h02, 0);
    step(1, 0, 8'h03, 1);
`ifdef DFF_DELAY_LINE_OCC_EN
    if (bus.occ > occ_peak) occ_peak = int'(bus.occ);
`endif
    step(1, 0, 8'h04, 0);
    check("bub_e4_q", bus.q, 8'h01);
    check("bub_e4_q_valid", bus.q_valid, 1);
`ifdef DFF_DELAY_LINE_OCC_EN
    check("bub_e4_occ", bus.occ, 2);
    if (bus.occ > occ_peak) occ_peak = int'(bus.occ);
`endif
    step(1, 0, 8'h00, 0);
    check("bub_e5_q", bus.q, 8'h02);
    check("bub_e5_q_valid", bus.q_valid, 0);
`ifdef DFF_DELAY_LINE_OCC_EN
    check("bub_e5_occ", bus.occ, 1);
    if (bus.occ > occ_peak) occ_peak = int'(bus.occ);
`endif
    step(1, 0, 8'h00, 0);
    check("bub_e6_q", bus.q, 8'h03);
    check("bub_e6_q_valid", bus.q_valid, 1);
    step(1, 0, 8'h00, 0);
    check("bub_e7_q", bus.q, 8'h04);
    check("bub_e7_q_valid", bus.q_valid, 0);
`ifdef DFF_DELAY_LINE_OCC_EN
    check("bub_e7_occ", bus.occ, 0);
    check("bub_occ_peak", occ_peak, 2);
`endif

    // Async reset 2 ns after an edge with the line full
    step(1, 0, 8'hC1, 1);
    step(1, 0, 8'hC2, 1);
    step(1, 0, 8'hC3, 1);
    step(1, 0, 8'hC4, 1);
    check("arst_full_q", bus.q, 8'hC1);
    bus.en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", bus.q, 0);
    check("arst_q_valid", bus.q_valid, 0);
`ifdef DFF_DELAY_LINE_OCC_EN
    check("arst_occ", bus.occ, 0);
`endif
    #2 rst_n = 1'b1;
    bus.en      = 1'b1;
    bus.d       = 8'hD1;
    bus.d_valid = 1'b1;
    #1;
    check("arst_release_q_valid", bus.q_valid, 0);
    step(1, 0, 8'hD1, 1);
    step(1, 0, 8'hD2, 1);
    step(1, 0, 8'hD3, 1);
    check("arst_refill_e3_q_valid", bus.q_valid, 0);
    step(1, 0, 8'hD4, 1);
    check("arst_refill_e4_q", bus.q, 8'hD1);
    check("arst_refill_e4_q_valid", bus.q_valid, 1);

    // DEPTH=1: single enabled flop
    bus.en       = 1'b0;
    bus1.en      = 1'b1;
    bus1.d       = 8'h5A;
    bus1.d_valid = 1'b1;
    @(posedge clk);
    #1;
    check("d1_q", bus1.q, 8'h5A);
    check("d1_q_valid", bus1.q_valid, 1);
`ifdef DFF_DELAY_LINE_OCC_EN
    check("d1_occ", bus1.occ, 1);
`endif
    bus1.en = 1'b0;
    bus1.d  = 8'hFF;
    @(posedge clk);
    #1;
    check("d1_hold_q", bus1.q, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dff_delay_line.md
DFF_DELAY_LINE -- requirements
Module: dff_delay_line

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data bits per stage (legal range 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of register stages (legal range 1..32).
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port EN, input, 1 bit, the advance enable; 0 holds every stage.
REQ-006 The block SHALL have port CLR, input, 1 bit, the synchronous flush of all stages.
REQ-007 The block SHALL have port D, input, WIDTH bits, the data into stage 0.
REQ-008 The block SHALL have port D_VALID, input, 1 bit, marking D as a valid sample.
REQ-009 The block SHALL have port Q, output, WIDTH bits, the data of the last stage (DEPTH-1).
REQ-010 The block SHALL have port Q_VALID, output, 1 bit, the valid flag of the last stage.
REQ-011 The block SHALL have port OCC, output, clog2(DEPTH+1) bits, the count of valid stages; it is present only with DFF_DELAY_LINE_OCC_EN.

Function
REQ-012 Each stage i SHALL hold a WIDTH-bit data register and a 1-bit valid flag, both updated only on the rising edge of CLK.
REQ-013 With EN=1 and CLR=0, at each edge stage 0 SHALL load D and D_VALID, and stage i (i>0) SHALL load stage i-1.
REQ-014 Latency SHALL be exactly DEPTH enabled edges: a sample presented at enabled edge n SHALL appear on Q/Q_VALID after enabled edge n+DEPTH-1.
REQ-015 With DEPTH=1 the block SHALL behave as a single D flip-flop with enable and valid.
REQ-016 With EN=0 and CLR=0, all stages SHALL hold their value, and D and D_VALID SHALL be ignored.
REQ-017 With CLR=1, at the edge all data registers SHALL become 0 and all valid flags 0, regardless of EN.
REQ-018 When CLR=1 coincides with EN=1, CLR SHALL take priority and D SHALL NOT be captured.
REQ-019 Invalid samples (D_VALID=0) SHALL still shift their data bits; only the valid flag marks them.
REQ-020 Q and Q_VALID SHALL be driven directly from last-stage registers, with no combinational path from D, EN or CLR.
REQ-021 When enabled, OCC SHALL update as OCC + D_VALID - Q_VALID(pre-edge); when EN=0 it SHALL hold, and when CLR=1 it SHALL become 0.
REQ-022 OCC SHALL never exceed DEPTH and SHALL always equal the number of set valid flags.

Reset
REQ-023 RST_N=0 SHALL immediately, without a clock, force all data registers, valid flags, Q, Q_VALID and OCC to 0.
REQ-024 A reset asserted mid-operation SHALL discard all in-flight samples.
REQ-025 After RST_N rises, the first state change SHALL occur on the next rising CLK edge.

Configuration
REQ-026 With macro DFF_DELAY_LINE_OCC_EN defined, the OCC port and its counter SHALL be compiled in per REQ-011, REQ-021 and REQ-022.
REQ-027 Without DFF_DELAY_LINE_OCC_EN, the OCC port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8, DEPTH=4)
REQ-028 The bench SHALL cover the latency case: EN=1, D_VALID=1, D=0x11,0x22,0x33,0x44,0x55 on successive edges -> Q=0x11 with Q_VALID=1 after the 4th edge, then 0x22 after the 5th.
REQ-029 The bench SHALL cover the stall case: fill with 0xA1..0xA4, then EN=0 for 3 edges while D=0xFF -> Q stays 0xA1 and OCC stays 4; EN=1 -> Q=0xA2.
REQ-030 The bench SHALL cover the flush case: pipeline full, CLR=1 with EN=1 and D=0x77 -> next edge Q=0, Q_VALID=0, OCC=0; 0x77 never appears on Q.
REQ-031 The bench SHALL cover the bubble case: D_VALID pattern 1,0,1,0 with D=0x01..0x04 -> Q_VALID sequence 1,0,1,0 starting after edge 4; OCC peaks at 2.
REQ-032 The bench SHALL cover the async reset case: RST_N pulled low 2 ns after an edge with the pipeline full -> Q, Q_VALID and OCC are 0 before the next edge.
REQ-033 The bench SHALL cover DEPTH=1: D=0x5A with EN=1 -> Q=0x5A one edge later.
